// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic arbiter with registered one-hot grant, round-robin or fixed priority.
// Optional watchdog that aborts hung cycles is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_n #(
   parameter int NUM_MASTERS           = 4,
   parameter int DATA_WIDTH            = 32,
   parameter int ADDR_WIDTH            = 32,
   parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
   parameter bit ARB_ROUND_ROBIN       = 1'b1,
   parameter bit ARB_LSB_HIGH_PRIORITY = 1'b1,
   parameter int TIMEOUT_CYCLES        = 255
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_i,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_o,
   input  logic [NUM_MASTERS-1:0]              wbm_we_i,
   input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]              wbm_stb_i,
   input  logic [NUM_MASTERS-1:0]              wbm_cyc_i,
   output logic [NUM_MASTERS-1:0]              wbm_ack_o,
   output logic [NUM_MASTERS-1:0]              wbm_err_o,
   output logic [ADDR_WIDTH-1:0]               wbs_adr_o,
   output logic [DATA_WIDTH-1:0]               wbs_dat_o,
   output logic                                wbs_we_o,
   output logic [SELECT_WIDTH-1:0]             wbs_sel_o,
   output logic                                wbs_stb_o,
   output logic                                wbs_cyc_o,
   input  logic [DATA_WIDTH-1:0]               wbs_dat_i,
   input  logic                                wbs_ack_i,
   input  logic                                wbs_err_i,
   output logic [NUM_MASTERS-1:0]              grant_o
);

   localparam int IDX_W = $clog2(NUM_MASTERS);

   typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [IDX_W-1:0]       win_idx;
   logic                   g_cyc, g_stb;
   logic                   bus_on;
   logic                   timeout_hit;

   // Winner selection; in round-robin the lowest requester above last_q overrides the wrap-around pick.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      win_idx = '0;
      if (ARB_ROUND_ROBIN || ARB_LSB_HIGH_PRIORITY) begin
         for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (wbm_cyc_i[i]) win_idx = IDX_W'(i);
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++)
            if (wbm_cyc_i[i]) win_idx = IDX_W'(i);
      end
      if (ARB_ROUND_ROBIN) begin
         for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (wbm_cyc_i[i] && (IDX_W'(i) > last_q)) win_idx = IDX_W'(i);
      end
   end

   assign bus_on = (state_q == GRANT);

   always_comb begin
      g_cyc     = 1'b0;
      g_stb     = 1'b0;
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            g_cyc = wbm_cyc_i[i];
            g_stb = wbm_stb_i[i];
            if (bus_on) begin
               wbs_adr_o    = wbm_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
               wbs_dat_o    = wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
               wbs_sel_o    = wbm_sel_i[i*SELECT_WIDTH +: SELECT_WIDTH];
               wbs_we_o     = wbm_we_i[i];
               wbm_ack_o[i] = wbs_ack_i;
               wbm_err_o[i] = wbs_err_i | timeout_hit;
            end
         end
      end
   end

   assign wbs_cyc_o = bus_on & g_cyc;
   assign wbs_stb_o = bus_on & g_stb;
   assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
   assign grant_o   = grant_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (|wbm_cyc_i) begin
               state_d = GRANT;
               last_d  = win_idx;
               for (int i = 0; i < NUM_MASTERS; i++)
                  grant_d[i] = (IDX_W'(i) == win_idx);
            end
         end
         GRANT: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (timeout_hit) begin
               state_d = ABORT;
            end
         end
         ABORT: begin
            if (!g_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wd_q, wd_d;

   // Fires in the TIMEOUT_CYCLES-th consecutive stalled strobe cycle of the current owner.
   always_comb begin
      wd_d        = wd_q;
      timeout_hit = 1'b0;
      if (!bus_on || wbs_ack_i || wbs_err_i) begin
         wd_d = '0;
      end else if (g_stb) begin
         if (wd_q == WD_LAST) begin
            timeout_hit = 1'b1;
            wd_d        = '0;
         end else begin
            wd_d = wd_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

endmodule
